// File: rtl/edp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | edp_pkg : shared EDP control codes, sequencer states and controls   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package edp_pkg;

  localparam logic [5:0] AD_A       = 6'o37;
  localparam logic [5:0] AD_B       = 6'o32;
  localparam logic [5:0] AD_0S      = 6'o34;
  localparam logic [5:0] AD_APLUSB  = 6'o06;
  localparam logic [5:0] AD_AMINUSB = 6'o31;

  localparam logic [2:0] ADA_AR = 3'd0;
  localparam logic [1:0] ADB_BR = 2'd2;

  localparam logic [2:0] AR_HOLD   = 3'd0;
  localparam logic [2:0] AR_CACHE  = 3'd1;
  localparam logic [2:0] AR_AD     = 3'd2;
  localparam logic [2:0] AR_ADHALF = 3'd7;

  localparam logic [1:0] MQ_HOLD = 2'd0;
  localparam logic [1:0] MQ_SHRT = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_STEP = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mpy_state_t;

  typedef struct packed {
    logic       ready;
    logic       active;
    logic       done;
    logic       booth;      // AD function comes from the Booth decoder
    logic [5:0] ad;
    logic       ada_en;
    logic [2:0] ada;
    logic [1:0] adb;
    logic       brload;
    logic [2:0] ar_sel_l;
    logic [2:0] ar_sel_r;
    logic       ar_load;
    logic [1:0] mq_sel;
    logic [1:0] mqm_sel;
    logic       mqm_en;
  } mpy_ctl_t;

  // Control word presented while the sequencer sits in state s.
  function automatic mpy_ctl_t ctl_for(input mpy_state_t s);
    mpy_ctl_t c;
    c          = '0;
    c.ad       = AD_A;
    c.ar_sel_l = AR_HOLD;
    c.ar_sel_r = AR_HOLD;
    case (s)
      S_IDLE: c.ready = 1'b1;
      S_LOAD: begin
        c.active   = 1'b1;
        c.brload   = 1'b1;
        c.ad       = AD_0S;
        c.ar_sel_l = AR_AD;
        c.ar_sel_r = AR_AD;
        c.ar_load  = 1'b1;
        c.mq_sel   = MQ_HOLD;
      end
      S_STEP: begin
        c.active   = 1'b1;
        c.booth    = 1'b1;
        c.ada      = ADA_AR;
        c.adb      = ADB_BR;
        c.ar_sel_l = AR_ADHALF;
        c.ar_sel_r = AR_ADHALF;
        c.ar_load  = 1'b1;
        c.mq_sel   = MQ_SHRT;
        c.mqm_en   = 1'b1;
      end
      S_FIX: begin
        c.active   = 1'b1;
        c.booth    = 1'b1;
        c.ada      = ADA_AR;
        c.adb      = ADB_BR;
        c.ar_sel_l = AR_AD;
        c.ar_sel_r = AR_AD;
        c.ar_load  = 1'b1;
        c.mq_sel   = MQ_HOLD;
      end
      S_DONE: begin
        c.active = 1'b1;
        c.done   = 1'b1;
      end
      default: c.ready = 1'b1;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edp_mpy_booth_dec.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | edp_mpy_booth_dec : radix-2 Booth pair {MQ35,q} -> AD code, carry   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module edp_mpy_booth_dec
  import edp_pkg::*;
(
  input  logic       mq35,
  input  logic       q,
  output logic [5:0] ad,
  output logic       carry36
);

  always_comb begin
    ad      = AD_A;
    carry36 = 1'b0;
    case ({mq35, q})
      2'b01: ad = AD_APLUSB;
      2'b10: begin
        ad      = AD_AMINUSB;
        carry36 = 1'b1;
      end
      default: ad = AD_A;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/edp_mpy_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | edp_mpy_seq : microsequencer for signed 36x36 Booth multiply on EDP |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module edp_mpy_seq
  import edp_pkg::*;
#(
  parameter int STEPS = 36
) (
  input  logic       eboxClk,
  input  logic       eboxReset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       EDP_MQ35,
  output logic       ready,
  output logic       seqActive,
  output logic       done,
  output logic [5:0] CRAM_AD,
  output logic       CRAM_ADA_EN,
  output logic [2:0] CRAM_ADA,
  output logic [1:0] CRAM_ADB,
  output logic       CRAM_BRload,
  output logic [2:0] CTL_ARL_SEL,
  output logic [2:0] CTL_ARR_SEL,
  output logic       CTL_AR00to08load,
  output logic       CTL_AR09to17load,
  output logic       CTL_ARRload,
  output logic       CTL_ADcarry36,
  output logic [1:0] CTL_MQ_SEL,
  output logic [1:0] CTL_MQM_SEL,
  output logic       CTL_MQM_EN,
  output logic [5:0] stepCount
);

  localparam logic [5:0] c_steps = 6'(STEPS);

  mpy_state_t r_state;
  mpy_ctl_t   r_ctl;
  logic [5:0] r_step_count;
  logic       r_q;
  logic [5:0] w_booth_ad;
  logic       w_booth_carry;

  edp_mpy_booth_dec u_booth_dec (
    .mq35    (EDP_MQ35),
    .q       (r_q),
    .ad      (w_booth_ad),
    .carry36 (w_booth_carry)
  );

  // Control word is registered for the state being entered, so it lines up with r_state.
  always_ff @(posedge eboxClk or negedge eboxReset_n) begin
    if (!eboxReset_n) begin
      r_state      <= S_IDLE;
      r_ctl        <= ctl_for(S_IDLE);
      r_step_count <= '0;
      r_q          <= 1'b0;
    end else if (r_state != S_IDLE && abort) begin
      r_state      <= S_IDLE;
      r_ctl        <= ctl_for(S_IDLE);
      r_step_count <= '0;
      r_q          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_LOAD;
            r_ctl        <= ctl_for(S_LOAD);
            r_step_count <= c_steps;
            r_q          <= 1'b0;
          end
        end
        S_LOAD: begin
          r_state <= S_STEP;
          r_ctl   <= ctl_for(S_STEP);
        end
        S_STEP: begin
          r_q          <= EDP_MQ35;
          r_step_count <= r_step_count - 6'd1;
          if (r_step_count == 6'd1) begin
            r_state <= S_FIX;
            r_ctl   <= ctl_for(S_FIX);
          end
        end
        S_FIX: begin
          r_state <= S_DONE;
          r_ctl   <= ctl_for(S_DONE);
        end
        default: begin
          r_state      <= S_IDLE;
          r_ctl        <= ctl_for(S_IDLE);
          r_step_count <= '0;
        end
      endcase
    end
  end

  assign ready            = r_ctl.ready;
  assign seqActive        = r_ctl.active;
  assign done             = r_ctl.done;
  assign CRAM_AD          = r_ctl.booth ? w_booth_ad : r_ctl.ad;
  assign CTL_ADcarry36    = r_ctl.booth & w_booth_carry;
  assign CRAM_ADA_EN      = r_ctl.ada_en;
  assign CRAM_ADA         = r_ctl.ada;
  assign CRAM_ADB         = r_ctl.adb;
  assign CRAM_BRload      = r_ctl.brload;
  assign CTL_ARL_SEL      = r_ctl.ar_sel_l;
  assign CTL_ARR_SEL      = r_ctl.ar_sel_r;
  assign CTL_AR00to08load = r_ctl.ar_load;
  assign CTL_AR09to17load = r_ctl.ar_load;
  assign CTL_ARRload      = r_ctl.ar_load;
  assign CTL_MQ_SEL       = r_ctl.mq_sel;
  assign CTL_MQM_SEL      = r_ctl.mqm_sel;
  assign CTL_MQM_EN       = r_ctl.mqm_en;
  assign stepCount        = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_edp_mpy_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_edp_mpy_seq : edp_mpy_seq driving a small EDP AR/BR/MQ model     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_edp_mpy_seq;
  import edp_pkg::*;

  logic eboxClk = 1'b0;
  always #5 eboxClk = ~eboxClk;

  logic eboxReset_n, start, abort, EDP_MQ35;
  logic ready, seqActive, done, CRAM_ADA_EN, CRAM_BRload, CTL_ADcarry36, CTL_MQM_EN;
  logic CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload;
  logic [5:0] CRAM_AD, stepCount;
  logic [2:0] CRAM_ADA, CTL_ARL_SEL, CTL_ARR_SEL;
  logic [1:0] CRAM_ADB, CTL_MQ_SEL, CTL_MQM_SEL;

  edp_mpy_seq #(.STEPS(36)) dut (
    .eboxClk(eboxClk), .eboxReset_n(eboxReset_n), .start(start), .abort(abort),
    .EDP_MQ35(EDP_MQ35), .ready(ready), .seqActive(seqActive), .done(done),
    .CRAM_AD(CRAM_AD), .CRAM_ADA_EN(CRAM_ADA_EN), .CRAM_ADA(CRAM_ADA), .CRAM_ADB(CRAM_ADB),
    .CRAM_BRload(CRAM_BRload), .CTL_ARL_SEL(CTL_ARL_SEL), .CTL_ARR_SEL(CTL_ARR_SEL),
    .CTL_AR00to08load(CTL_AR00to08load), .CTL_AR09to17load(CTL_AR09to17load),
    .CTL_ARRload(CTL_ARRload), .CTL_ADcarry36(CTL_ADcarry36), .CTL_MQ_SEL(CTL_MQ_SEL),
    .CTL_MQM_SEL(CTL_MQM_SEL), .CTL_MQM_EN(CTL_MQM_EN), .stepCount(stepCount)
  );

  // ---------------- EDP datapath model (AR, BR, MQ, AD) ----------------
  logic [35:0] ar, br, mq, tb_ar, tb_mq;
  logic        tb_load, mq35_force_en, mq35_force;
  logic signed [36:0] edp_a, edp_b, edp_ad;
  logic [35:0] ar_l_next, ar_r_next;

  assign EDP_MQ35 = mq35_force_en ? mq35_force : mq[0];

  always_comb begin
    edp_a = {ar[35], ar};
    edp_b = {br[35], br};
    case (CRAM_AD)
      AD_A:       edp_ad = edp_a;
      AD_B:       edp_ad = edp_b;
      AD_0S:      edp_ad = '0;
      AD_APLUSB:  edp_ad = edp_a + edp_b;
      AD_AMINUSB: edp_ad = edp_a + ~edp_b + 37'(CTL_ADcarry36);
      default:    edp_ad = edp_a;
    endcase
  end

  function automatic logic [35:0] ar_mux(input logic [2:0] sel, input logic [36:0] ad,
                                         input logic [35:0] cur, input logic [35:0] cache);
    case (sel)
      AR_AD:     return ad[35:0];
      AR_ADHALF: return ad[36:1];
      AR_CACHE:  return cache;
      default:   return cur;
    endcase
  endfunction

  assign ar_l_next = ar_mux(tb_load ? AR_CACHE : CTL_ARL_SEL, edp_ad, ar, tb_ar);
  assign ar_r_next = ar_mux(tb_load ? AR_CACHE : CTL_ARR_SEL, edp_ad, ar, tb_ar);

  always @(posedge eboxClk) begin
    if (tb_load) begin
      ar <= tb_ar;
      mq <= tb_mq;
    end else begin
      if (CRAM_BRload)      br         <= ar;
      if (CTL_AR00to08load) ar[35:27]  <= ar_l_next[35:27];
      if (CTL_AR09to17load) ar[26:18]  <= ar_l_next[26:18];
      if (CTL_ARRload)      ar[17:0]   <= ar_r_next[17:0];
      if (CTL_MQ_SEL == MQ_SHRT) mq <= {edp_ad[0], mq[35:1]};
    end
  end

  // ---------------- checking infrastructure ----------------
  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  int done_cnt = 0;

  always @(posedge eboxClk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [35:0] ar;
    logic [35:0] mq;
    bit          chk_ar;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_exp(input string nm, input logic [35:0] e_ar, input logic [35:0] e_mq,
                          input bit c_ar);
    exp_t e;
    e.name = nm; e.ar = e_ar; e.mq = e_mq; e.chk_ar = c_ar; e.cyc = cyc_cnt + 38;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge eboxClk) begin
    if (eboxReset_n === 1'b1 && done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 72'd1, 72'd0);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_latency"}, 72'(cyc_cnt), 72'(e.cyc));
        chk({e.name, "_mq"}, 72'(mq), 72'(e.mq));
        if (e.chk_ar) chk({e.name, "_ar"}, 72'(ar), 72'(e.ar));
      end
    end
  end

  task automatic cyc();
    @(posedge eboxClk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_ready"}, 72'(ready), 72'd1);
    chk({nm, "_active"}, 72'(seqActive), 72'd0);
    chk({nm, "_done"}, 72'(done), 72'd0);
    chk({nm, "_ad"}, 72'(CRAM_AD), 72'(AD_A));
    chk({nm, "_arsel"}, 72'({CTL_ARL_SEL, CTL_ARR_SEL}), 72'({AR_HOLD, AR_HOLD}));
    chk({nm, "_stepcount"}, 72'(stepCount), 72'd0);
    chk({nm, "_strobes"}, 72'({CTL_AR00to08load, CTL_AR09to17load, CTL_ARRload, CRAM_BRload,
                               CTL_MQM_EN, CTL_ADcarry36, CRAM_ADA_EN, CRAM_ADA, CRAM_ADB,
                               CTL_MQ_SEL, CTL_MQM_SEL}), 72'd0);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    chk({nm, "_ready_again"}, 72'(ready), 72'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    eboxReset_n = 1'b0; start = 1'b0; abort = 1'b0;
    tb_load = 1'b0; tb_ar = '0; tb_mq = '0; mq35_force_en = 1'b0; mq35_force = 1'b0;
    repeat (3) cyc();
    check_idle("reset");
    eboxReset_n = 1'b1;
    cyc();

    // 1: 5 * 3; low word 15
    tb_load = 1'b1; tb_ar = 36'd5; tb_mq = 36'd3;
    cyc();
    tb_load = 1'b0; start = 1'b1;
    cyc();
    push_exp("mul_5x3", 36'd0, 36'h00000000F, 1'b0);
    start = 1'b0;
    wait_ready("t1");

    // 2: (2^35-1) * -1 = -(2^35-1)
    tb_load = 1'b1; tb_ar = 36'h7FFFFFFFF; tb_mq = 36'hFFFFFFFFF;
    cyc();
    tb_load = 1'b0; start = 1'b1;
    cyc();
    push_exp("mul_max_neg1", 36'hFFFFFFFFF, 36'h800000001, 1'b1);
    start = 1'b0;
    wait_ready("t2");

    // 3: async reset while in STEP
    tb_load = 1'b1; tb_ar = 36'd5; tb_mq = 36'd3; start = 1'b1;
    cyc();
    tb_load = 1'b0; start = 1'b0;
    repeat (11) cyc();
    chk("midstep_active", 72'(seqActive), 72'd1);
    chk("midstep_stepcount", 72'(stepCount), 72'd26);
    #2 eboxReset_n = 1'b0;
    #1 check_idle("async_reset");
    cyc();
    eboxReset_n = 1'b1;
    cyc();
    chk("post_reset_ready", 72'(ready), 72'd1);

    // 4: abort during step 10, restart immediately with new operands (-3 * 6 = -18)
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (10) cyc();
    chk("abort_pre_stepcount", 72'(stepCount), 72'd27);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check_idle("abort");
    tb_load = 1'b1; tb_ar = 36'hFFFFFFFFD; tb_mq = 36'd6; start = 1'b1;
    cyc();
    push_exp("mul_m3x6", 36'hFFFFFFFFF, 36'hFFFFFFFEE, 1'b1);
    tb_load = 1'b0; start = 1'b0;
    chk("restart_active", 72'(seqActive), 72'd1);
    chk("restart_stepcount", 72'(stepCount), 72'd36);
    wait_ready("t4");

    // 5: start held 50 cycles: 7 * -3 = -21, then a second op (-1 * -21 = 21)
    tb_load = 1'b1; tb_ar = 36'd7; tb_mq = 36'hFFFFFFFFD; start = 1'b1;
    n0 = done_cnt;
    cyc();
    push_exp("mul_7xm3", 36'hFFFFFFFFF, 36'hFFFFFFFEB, 1'b1);
    tb_load = 1'b0;
    for (int i = 1; i < 50; i++) begin
      cyc();
      if (i == 38) chk("held_done_cycle_ready", 72'({ready, done}), 72'b01);
      if (i == 39) chk("held_ready_returns", 72'({ready, seqActive}), 72'b10);
      if (i == 40) begin
        chk("held_second_op", 72'({seqActive, stepCount}), 72'({1'b1, 6'd36}));
        push_exp("mul_m1xm21", 36'd0, 36'h000000015, 1'b1);
      end
    end
    start = 1'b0;
    @(negedge eboxClk);
    #1 chk("held_one_done", 72'(done_cnt - n0), 72'd1);
    cyc();
    wait_ready("t5");

    // 6: simultaneous start+abort in IDLE, then forced Booth bits 1,0,1,1
    start = 1'b1; abort = 1'b1; mq35_force_en = 1'b1; mq35_force = 1'b0;
    cyc();
    start = 1'b0; abort = 1'b0;
    chk("start_beats_abort", 72'(seqActive), 72'd1);
    chk("load_ctl", 72'({CRAM_BRload, CRAM_AD, CTL_ARL_SEL, CTL_ARR_SEL, CTL_ARRload, CTL_MQ_SEL}),
        72'({1'b1, AD_0S, AR_AD, AR_AD, 1'b1, MQ_HOLD}));
    cyc();
    mq35_force = 1'b1; #1;
    chk("booth_1_ad", 72'({CRAM_AD, CTL_ADcarry36}), 72'({AD_AMINUSB, 1'b1}));
    chk("step_ctl", 72'({CRAM_ADA, CRAM_ADB, CTL_ARR_SEL, CTL_ARL_SEL, CTL_MQ_SEL, CTL_MQM_EN}),
        72'({ADA_AR, ADB_BR, AR_ADHALF, AR_ADHALF, MQ_SHRT, 1'b1}));
    cyc();
    mq35_force = 1'b0; #1;
    chk("booth_2_ad", 72'({CRAM_AD, CTL_ADcarry36}), 72'({AD_APLUSB, 1'b0}));
    cyc();
    mq35_force = 1'b1; #1;
    chk("booth_3_ad", 72'({CRAM_AD, CTL_ADcarry36}), 72'({AD_AMINUSB, 1'b1}));
    cyc();
    mq35_force = 1'b1; #1;
    chk("booth_4_ad", 72'({CRAM_AD, CTL_ADcarry36}), 72'({AD_A, 1'b0}));
    abort = 1'b1;
    cyc();
    abort = 1'b0; mq35_force_en = 1'b0;
    check_idle("abort6");

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
        cyc();
        n++;
      end
    end
    chk("scoreboard_drained", 72'(exp_q.size()), 72'd0);
    repeat (5) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
